i2d_pipe_ctl: RTL

- Pipeline sequencing controller for the i2d core.
- Takes decode-stage status (error, software interrupt, branch, register-read indices), execute-stage branch resolution and load destination, memory wait and external interrupt.
- Drives stall, bubble, discard and PC-select controls for the IF/ID/EX registers.
- Captures exception PC and cause for the system register logic.

---
 rtl/i2d_pipe_ctl.sv | 73 +++++++
 1 files changed

// File: rtl/i2d_pipe_ctl.sv
// i2d_pipe_ctl: pipeline stall/flush/exception sequencing for the i2d core
module i2d_pipe_ctl #(
   parameter int FLUSH_DEPTH = 1,
   parameter int VEC_CYCLES  = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [5:0]  id_ra,
   input  logic [5:0]  id_rb,
   input  logic        id_rf_r,
   input  logic        id_err,
   input  logic        swi,
   input  logic        ex_load,
   input  logic [5:0]  ex_rd,
   input  logic        ex_taken,
   input  logic        irq,
   input  logic        sr_ie,
   input  logic        mem_busy,
   output logic        pc_stall,
   output logic        id_stall,
   output logic        ex_stall,
   output logic        ex_bubble,
   output logic        if_dis,
   output logic [1:0]  pc_sel,
   output logic        exc_enter,
   output logic [31:0] epc,
   output logic [3:0]  cause
);
   typedef enum logic [1:0] {RUN, FLUSH, EXC} state_t;
   localparam logic [2:0] FLUSH_LD = 3'(FLUSH_DEPTH - 1);
   localparam logic [2:0] VEC_LD   = 3'(VEC_CYCLES - 1);
   state_t     state;
   logic [2:0] cnt;
   logic       id_exc, exc, hazard, run;
   assign id_exc = id_valid & (id_err | swi);
   assign exc    = id_exc | (irq & sr_ie);
   assign hazard = id_valid & id_rf_r & ex_load & (ex_rd != 6'd0) & ((ex_rd == id_ra) | (ex_rd == id_rb));
   assign run    = rst & ~mem_busy & (state == RUN);
   always_comb begin
      pc_stall  = ~rst ? 1'b0 : mem_busy | (run & ~ex_taken & ~exc & hazard);
      id_stall  = pc_stall;
      ex_stall  = rst & mem_busy;
      exc_enter = run & ~ex_taken & exc;
      ex_bubble = run & (ex_taken | exc | hazard);
      if_dis    = ~rst | (~mem_busy & (state != RUN | ex_taken | exc_enter));
      pc_sel    = (~rst | mem_busy)                   ? 2'b00 :
                  (state == EXC)                      ? 2'b10 :
                  (ex_taken & (state == FLUSH | run)) ? 2'b01 : 2'b00;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= RUN;
         cnt   <= 3'd0;
         epc   <= 32'd0;
         cause <= 4'd0;
      end else if (!mem_busy) begin
         if (state != EXC && ex_taken) begin
            state <= FLUSH;
            cnt   <= FLUSH_LD;
         end else if (state == RUN && exc) begin
            state <= EXC;
            cnt   <= VEC_LD;
            epc   <= id_pc;
            cause <= (id_valid & id_err) ? 4'd1 : (id_valid & swi) ? 4'd2 : 4'd3;
         end else if (state != RUN) begin
            state <= (cnt == 3'd0) ? RUN : state;
            cnt   <= (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
         end
      end
   end
endmodule
